// File: rtl/mil1553_pkg.sv
// mil1553_pkg
// Shared types and constants for the PMOD1553 transmit path.
//   state_t            : message arbiter FSM states
//   TUSER_SYNC_*       : meaning of tuser bit0 (sync pattern selection)
//   DEFAULT_*_CYCLES   : default timing for a 100 MHz system clock
//   cnt_width()        : counter width able to hold 0..max_val (never below 1)

package mil1553_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } state_t;

   // tuser bit0 selects the sync pattern the encoder puts in front of a word
   localparam logic TUSER_SYNC_CMD_STATUS = 1'b1;
   localparam logic TUSER_SYNC_DATA       = 1'b0;

   // 4 us minimum bus gap at 100 MHz
   localparam int DEFAULT_GAP_CYCLES   = 400;
   localparam int DEFAULT_STALL_CYCLES = 2000;

   // A zero maximum still needs a 1-bit counter so the vector is legal
   function automatic int cnt_width(input int max_val);
      if (max_val < 1) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mil1553_rr_pick.sv
// mil1553_rr_pick
// Combinational 2-input round-robin picker.
//   req[1:0]   : request per port (bit N = port N)
//   last_grant : port index that completed the most recent message
//   grant[1:0] : one-hot pick, 00 when no request
// On a tie the port that was not served last wins.

module mil1553_rr_pick (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // Single requests win outright; a tie goes to the opposite of last_grant
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mil1553_tx_arbiter.sv
// mil1553_tx_arbiter
// Message-level arbiter in front of the single MIL-STD-1553 transmit encoder.
// Whole messages are granted round-robin between two AXIS word streams, a
// minimum idle gap is enforced between messages, and a message whose granted
// source stops presenting words for STALL_CYCLES clocks is aborted.
// Ports:
//   aclk, aresetn          : clock, synchronous active-low reset
//   s0_* / s1_*            : requester word streams (tdata, tuser, tvalid, tlast, tready)
//   m_*                    : stream to the encoder (tdata, tuser, tvalid, tlast, tready)
//   grant[1:0]             : one-hot active grant, 00 when no message owns the bus
//   abort                  : one-cycle pulse when a stalled message is dropped
//   msg_count              : completed messages, wraps to 0

module mil1553_tx_arbiter
   import mil1553_pkg::*;
#(
   parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES,
   parameter int STALL_CYCLES = DEFAULT_STALL_CYCLES,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [15:0]          s0_tdata,
   input  logic [7:0]           s0_tuser,
   input  logic                 s0_tvalid,
   input  logic                 s0_tlast,
   output logic                 s0_tready,
   input  logic [15:0]          s1_tdata,
   input  logic [7:0]           s1_tuser,
   input  logic                 s1_tvalid,
   input  logic                 s1_tlast,
   output logic                 s1_tready,
   output logic [15:0]          m_tdata,
   output logic [7:0]           m_tuser,
   output logic                 m_tvalid,
   output logic                 m_tlast,
   input  logic                 m_tready,
   output logic [1:0]           grant,
   output logic                 abort,
   output logic [CNT_WIDTH-1:0] msg_count
);

   localparam int GAP_W   = cnt_width(GAP_CYCLES);
   localparam int STALL_W = cnt_width(STALL_CYCLES);

   localparam logic [GAP_W-1:0]   GAP_LOAD    = GAP_W'(GAP_CYCLES);
   localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_CYCLES);

   state_t               state;
   state_t               state_next;
   logic [1:0]           grant_q;
   logic [1:0]           grant_next;
   logic                 last_grant;
   logic                 last_grant_next;
   logic [STALL_W-1:0]   stall_cnt;
   logic [STALL_W-1:0]   stall_next;
   logic [GAP_W-1:0]     gap_cnt;
   logic [GAP_W-1:0]     gap_next;
   logic [CNT_WIDTH-1:0] msg_cnt_q;
   logic [CNT_WIDTH-1:0] msg_cnt_next;

   logic [1:0]  req;
   logic [1:0]  pick_grant;
   logic        sel;
   logic        sel_valid;
   logic        sel_last;
   logic [15:0] sel_data;
   logic [7:0]  sel_user;

   assign req = {s1_tvalid, s0_tvalid};

   mil1553_rr_pick u_pick (
      .req        (req),
      .last_grant (last_grant),
      .grant      (pick_grant)
   );

   // grant_q is one-hot while in XFER, so its upper bit selects the source
   assign sel       = grant_q[1];
   assign sel_valid = sel ? s1_tvalid : s0_tvalid;
   assign sel_last  = sel ? s1_tlast  : s0_tlast;
   assign sel_data  = sel ? s1_tdata  : s0_tdata;
   assign sel_user  = sel ? s1_tuser  : s0_tuser;

   assign grant     = grant_q;
   assign msg_count = msg_cnt_q;

   // Next-state and output decode. An abort takes priority over any word
   // presented in the same cycle, so nothing is handshaken while it pulses.
   // The gap counter is loaded with GAP_CYCLES and leaves GAP when it would
   // count down to zero, giving GAP_CYCLES idle clocks (one when it is 0).
   always_comb begin
      state_next      = state;
      grant_next      = grant_q;
      last_grant_next = last_grant;
      stall_next      = stall_cnt;
      gap_next        = gap_cnt;
      msg_cnt_next    = msg_cnt_q;
      m_tdata         = 16'h0000;
      m_tuser         = 8'h00;
      m_tvalid        = 1'b0;
      m_tlast         = 1'b0;
      s0_tready       = 1'b0;
      s1_tready       = 1'b0;
      abort           = 1'b0;

      case (state)
         IDLE: begin
            stall_next = '0;
            if (req != 2'b00) begin
               grant_next = pick_grant;
               state_next = XFER;
            end
         end

         XFER: begin
            m_tdata = sel_data;
            m_tuser = sel_user;
            m_tlast = sel_last;
            if (stall_cnt == STALL_LIMIT) begin
               abort      = 1'b1;
               grant_next = 2'b00;
               stall_next = '0;
               gap_next   = GAP_LOAD;
               state_next = GAP;
            end else begin
               m_tvalid  = sel_valid;
               s0_tready = ~sel & m_tready;
               s1_tready = sel & m_tready;
               if (sel_valid && m_tready) begin
                  stall_next = '0;
                  if (sel_last) begin
                     msg_cnt_next    = msg_cnt_q + CNT_WIDTH'(1);
                     last_grant_next = sel;
                     grant_next      = 2'b00;
                     gap_next        = GAP_LOAD;
                     state_next      = GAP;
                  end
               end else if (!sel_valid) begin
                  stall_next = stall_cnt + STALL_W'(1);
               end
            end
         end

         GAP: begin
            if (gap_cnt <= GAP_W'(1)) begin
               state_next = IDLE;
            end else begin
               gap_next = gap_cnt - GAP_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
            grant_next = 2'b00;
         end
      endcase
   end

   // State register; last_grant resets to port 1 so port 0 wins the first tie
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state      <= IDLE;
         grant_q    <= 2'b00;
         last_grant <= 1'b1;
         stall_cnt  <= '0;
         gap_cnt    <= '0;
         msg_cnt_q  <= '0;
      end else begin
         state      <= state_next;
         grant_q    <= grant_next;
         last_grant <= last_grant_next;
         stall_cnt  <= stall_next;
         gap_cnt    <= gap_next;
         msg_cnt_q  <= msg_cnt_next;
      end
   end

endmodule

// File: tb/tb_mil1553_tx_arbiter.sv
// tb_mil1553_tx_arbiter
// Self-checking bench for mil1553_tx_arbiter (GAP=4, STALL=10, 3-bit counter).
// A message-level reference model (owner / earliest-free-cycle / low-run)
// predicts every output each cycle; directed tables and sequences add
// hand-derived expectations for the documented corner cases.

module tb_mil1553_tx_arbiter;

   localparam int GAP     = 4;
   localparam int STALL   = 10;
   localparam int CW      = 3;
   localparam int GAP_LEN = (GAP == 0) ? 1 : GAP;

   typedef struct {
      logic [15:0] data;
      logic [7:0]  user;
      logic        last;
   } word_t;

   typedef struct {
      logic        v0;
      logic [15:0] d0;
      logic        l0;
      logic [1:0]  e_grant;
      logic        e_mvalid;
      logic [15:0] e_mdata;
      logic        e_mlast;
      logic        e_s0rdy;
      logic [2:0]  e_count;
   } vec_t;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [15:0]   s0_tdata, s1_tdata;
   logic [7:0]    s0_tuser, s1_tuser;
   logic          s0_tvalid, s1_tvalid, s0_tlast, s1_tlast;
   logic          s0_tready, s1_tready;
   logic [15:0]   m_tdata;
   logic [7:0]    m_tuser;
   logic          m_tvalid, m_tlast, m_tready;
   logic [1:0]    grant;
   logic          abort;
   logic [CW-1:0] msg_count;

   always #5 aclk = ~aclk;

   mil1553_tx_arbiter #(
      .GAP_CYCLES   (GAP),
      .STALL_CYCLES (STALL),
      .CNT_WIDTH    (CW)
   ) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .s0_tdata  (s0_tdata),
      .s0_tuser  (s0_tuser),
      .s0_tvalid (s0_tvalid),
      .s0_tlast  (s0_tlast),
      .s0_tready (s0_tready),
      .s1_tdata  (s1_tdata),
      .s1_tuser  (s1_tuser),
      .s1_tvalid (s1_tvalid),
      .s1_tlast  (s1_tlast),
      .s1_tready (s1_tready),
      .m_tdata   (m_tdata),
      .m_tuser   (m_tuser),
      .m_tvalid  (m_tvalid),
      .m_tlast   (m_tlast),
      .m_tready  (m_tready),
      .grant     (grant),
      .abort     (abort),
      .msg_count (msg_count)
   );

   int compared   = 0;
   int mismatched = 0;
   int tb_cyc     = 0;

   // reference model: who owns the bus, when arbitration may next happen
   bit m_ok    = 1'b0;
   int m_owner = -1;
   int m_last  = 1;
   int m_low   = 0;
   int m_free  = 0;
   int m_count = 0;

   // source engine and logs
   word_t      q0[$];
   word_t      q1[$];
   bit         rdy_q[$];
   int         hold0 = 0, hold1 = 0;
   bit         acc0 = 0, acc1 = 0;
   bit         rnd_mode = 0;
   logic       rstn_drv = 1'b0;
   logic [1:0] grant_log[$];
   int         grant_cyc[$];
   logic [15:0] out_log[$];
   logic [1:0] prev_grant = 2'b00;
   int         abort_cnt = 0;
   int         abort_cyc = -1;
   int         acc0_cyc = -1;

   vec_t tbl[12];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, tb_cyc, act, exp);
      end
   endtask

   function automatic word_t junk();
      word_t w;
      w.data = 16'($urandom);
      w.user = 8'($urandom);
      w.last = 1'($urandom);
      return w;
   endfunction

   function automatic int randHold();
      int r;
      r = $urandom_range(99);
      if (r < 70) return 0;
      if (r < 95) return $urandom_range(1, 4);
      return $urandom_range(STALL, STALL + 4);
   endfunction

   task automatic addMsg(input int port, input int n, input logic [15:0] base, input bit rnd);
      word_t w;
      for (int i = 0; i < n; i++) begin
         w.data = rnd ? 16'($urandom) : base + 16'(i);
         w.user = rnd ? 8'($urandom) : 8'h01;
         w.last = (i == n - 1);
         if (port == 0) q0.push_back(w);
         else q1.push_back(w);
      end
   endtask

   task automatic applyStimulus(input logic rstn, input word_t w0, input logic v0,
                                input word_t w1, input logic v1, input logic rdy);
      @(negedge aclk);
      aresetn   = rstn;
      s0_tvalid = v0;
      s0_tdata  = w0.data;
      s0_tuser  = w0.user;
      s0_tlast  = w0.last;
      s1_tvalid = v1;
      s1_tdata  = w1.data;
      s1_tuser  = w1.user;
      s1_tlast  = w1.last;
      m_tready  = rdy;
      #1;
   endtask

   task automatic modelAdvance();
      logic sv, sl;
      if (aresetn === 1'b0) begin
         m_ok    = 1'b1;
         m_owner = -1;
         m_last  = 1;
         m_low   = 0;
         m_count = 0;
         m_free  = tb_cyc + 1;
      end else if (m_ok) begin
         if (m_owner >= 0) begin
            sv = (m_owner == 1) ? s1_tvalid : s0_tvalid;
            sl = (m_owner == 1) ? s1_tlast : s0_tlast;
            if (m_low >= STALL) begin
               m_owner = -1;
               m_free  = tb_cyc + 1 + GAP_LEN;
            end else if (sv && m_tready) begin
               m_low = 0;
               if (sl) begin
                  m_count++;
                  m_last  = m_owner;
                  m_owner = -1;
                  m_free  = tb_cyc + 1 + GAP_LEN;
               end
            end else if (!sv) begin
               m_low++;
            end
         end else if (tb_cyc >= m_free && (s0_tvalid || s1_tvalid)) begin
            m_owner = (s0_tvalid && s1_tvalid) ? 1 - m_last : (s0_tvalid ? 0 : 1);
            m_low   = 0;
         end
      end
   endtask

   task automatic checkOutput();
      bit          busy, ab;
      logic        sv, sl;
      logic [15:0] sd;
      logic [7:0]  su;
      if (m_ok) begin
         busy = (m_owner >= 0);
         ab   = busy && (m_low >= STALL);
         sv   = (m_owner == 1) ? s1_tvalid : s0_tvalid;
         sl   = (m_owner == 1) ? s1_tlast : s0_tlast;
         sd   = (m_owner == 1) ? s1_tdata : s0_tdata;
         su   = (m_owner == 1) ? s1_tuser : s0_tuser;
         cmp("grant", grant, busy ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00);
         cmp("abort", abort, ab);
         cmp("m_tvalid", m_tvalid, busy && !ab && sv);
         cmp("m_tdata", m_tdata, busy ? sd : 16'h0);
         cmp("m_tuser", m_tuser, busy ? su : 8'h0);
         cmp("m_tlast", m_tlast, busy ? sl : 1'b0);
         cmp("s0_tready", s0_tready, busy && !ab && m_owner == 0 && m_tready);
         cmp("s1_tready", s1_tready, busy && !ab && m_owner == 1 && m_tready);
         cmp("msg_count", msg_count, m_count % (1 << CW));
      end
      acc0 = (s0_tvalid === 1'b1) && (s0_tready === 1'b1);
      acc1 = (s1_tvalid === 1'b1) && (s1_tready === 1'b1);
      if (acc0) acc0_cyc = tb_cyc;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) out_log.push_back(m_tdata);
      if (grant !== 2'b00 && prev_grant === 2'b00) begin
         grant_log.push_back(grant);
         grant_cyc.push_back(tb_cyc);
      end
      prev_grant = grant;
      if (abort === 1'b1) begin
         abort_cnt++;
         abort_cyc = tb_cyc;
      end
      modelAdvance();
      tb_cyc++;
   endtask

   task automatic engineCycle();
      word_t w0, w1;
      logic  v0, v1, rdy;
      if (acc0 && q0.size() > 0) begin
         void'(q0.pop_front());
         hold0 = rnd_mode ? randHold() : 0;
      end
      if (acc1 && q1.size() > 0) begin
         void'(q1.pop_front());
         hold1 = rnd_mode ? randHold() : 0;
      end
      if (rnd_mode) begin
         if (q0.size() == 0 && $urandom_range(3) == 0) addMsg(0, $urandom_range(1, 4), 16'h0, 1'b1);
         if (q1.size() == 0 && $urandom_range(3) == 0) addMsg(1, $urandom_range(1, 4), 16'h0, 1'b1);
      end
      v0 = (q0.size() > 0) && (hold0 == 0);
      v1 = (q1.size() > 0) && (hold1 == 0);
      if (hold0 > 0) hold0--;
      if (hold1 > 0) hold1--;
      w0 = v0 ? q0[0] : junk();
      w1 = v1 ? q1[0] : junk();
      if (rdy_q.size() > 0) rdy = rdy_q.pop_front();
      else rdy = rnd_mode ? ($urandom_range(3) != 0) : 1'b1;
      applyStimulus(rstn_drv, w0, v0, w1, v1, rdy);
      checkOutput();
   endtask

   task automatic clearLogs();
      grant_log.delete();
      grant_cyc.delete();
      out_log.delete();
      abort_cnt = 0;
      abort_cyc = -1;
      acc0_cyc  = -1;
   endtask

   task automatic doReset();
      q0.delete();
      q1.delete();
      rdy_q.delete();
      hold0    = 0;
      hold1    = 0;
      rstn_drv = 1'b0;
      repeat (2) engineCycle();
      rstn_drv = 1'b1;
      acc0     = 0;
      acc1     = 0;
      clearLogs();
   endtask

   function automatic logic [31:0] packGrants();
      logic [31:0] p = 0;
      for (int i = 0; i < grant_log.size() && i < 16; i++) p = (p << 2) | 32'(grant_log[i]);
      return p;
   endfunction

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      word_t w;
      word_t none;
      bit    found;

      none = '{16'h0, 8'h00, 1'b0};
      // single requester, GAP=4: 3-word message then a held 1-word message
      tbl[0]  = '{1'b1, 16'h1234, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0};
      tbl[1]  = '{1'b1, 16'h1234, 1'b0, 2'b01, 1'b1, 16'h1234, 1'b0, 1'b1, 3'd0};
      tbl[2]  = '{1'b1, 16'h5678, 1'b0, 2'b01, 1'b1, 16'h5678, 1'b0, 1'b1, 3'd0};
      tbl[3]  = '{1'b1, 16'h9ABC, 1'b1, 2'b01, 1'b1, 16'h9ABC, 1'b1, 1'b1, 3'd0};
      for (int i = 4; i <= 8; i++)
         tbl[i] = '{1'b1, 16'h0AAA, 1'b1, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1};
      tbl[9]  = '{1'b1, 16'h0AAA, 1'b1, 2'b01, 1'b1, 16'h0AAA, 1'b1, 1'b1, 3'd1};
      tbl[10] = '{1'b0, 16'h0000, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd2};
      tbl[11] = '{1'b0, 16'h0000, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd2};

      $display("[TB] start");
      doReset();

      // table-driven single requester
      for (int i = 0; i < 12; i++) begin
         w = '{tbl[i].d0, 8'h01, tbl[i].l0};
         applyStimulus(1'b1, w, tbl[i].v0, none, 1'b0, 1'b1);
         cmp("tbl_grant", grant, tbl[i].e_grant);
         cmp("tbl_m_tvalid", m_tvalid, tbl[i].e_mvalid);
         cmp("tbl_m_tdata", m_tdata, tbl[i].e_mdata);
         cmp("tbl_m_tlast", m_tlast, tbl[i].e_mlast);
         cmp("tbl_m_tuser", m_tuser, (tbl[i].e_grant != 2'b00) ? 8'h01 : 8'h00);
         cmp("tbl_s0_tready", s0_tready, tbl[i].e_s0rdy);
         cmp("tbl_msg_count", msg_count, tbl[i].e_count);
         checkOutput();
      end

      // simultaneous requests after reset: port 0 first
      doReset();
      addMsg(0, 2, 16'hA000, 1'b0);
      addMsg(1, 2, 16'hB100, 1'b0);
      repeat (20) engineCycle();
      cmp("simul_grant_count", grant_log.size(), 2);
      cmp("simul_grant_order", packGrants(), 32'h6);
      cmp("simul_msg_count", msg_count, 2);
      cmp("simul_words", out_log.size(), 4);
      if (out_log.size() == 4) begin
         cmp("simul_w0", out_log[0], 16'hA000);
         cmp("simul_w2", out_log[2], 16'hB100);
         cmp("simul_w3", out_log[3], 16'hB101);
      end

      // round-robin fairness over 6 one-word messages
      doReset();
      for (int i = 0; i < 3; i++) begin
         addMsg(0, 1, 16'h0100 + 16'(i), 1'b0);
         addMsg(1, 1, 16'h0200 + 16'(i), 1'b0);
      end
      repeat (45) engineCycle();
      cmp("rr_grant_count", grant_log.size(), 6);
      cmp("rr_grant_order", packGrants(), 32'h666);
      cmp("rr_msg_count", msg_count, 6 % (1 << CW));

      // backpressure on a 4-word s1 message, including a long ready-low run
      doReset();
      addMsg(1, 4, 16'hB000, 1'b0);
      rdy_q = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      repeat (30) engineCycle();
      cmp("bp_words", out_log.size(), 4);
      for (int i = 0; i < 4 && i < out_log.size(); i++)
         cmp("bp_word", out_log[i], 16'hB000 + 16'(i));
      cmp("bp_abort_count", abort_cnt, 0);
      cmp("bp_msg_count", msg_count, 1);

      // stall abort with a pending s1 request
      doReset();
      q0.push_back('{16'hE000, 8'h01, 1'b0});
      addMsg(1, 1, 16'hF000, 1'b0);
      repeat (40) engineCycle();
      cmp("stall_abort_count", abort_cnt, 1);
      cmp("stall_abort_cycle", abort_cyc, acc0_cyc + 1 + STALL);
      cmp("stall_grant_order", packGrants(), 32'h6);
      if (grant_cyc.size() == 2)
         cmp("stall_s1_grant_cycle", grant_cyc[1], abort_cyc + GAP + 2);
      else
         cmp("stall_grant_count", grant_cyc.size(), 2);
      cmp("stall_msg_count", msg_count, 1);

      // reset in the middle of a message
      doReset();
      addMsg(0, 3, 16'hC000, 1'b0);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         engineCycle();
         if (out_log.size() >= 1) found = 1;
      end
      cmp("rst_first_word_seen", found, 1'b1);
      rstn_drv = 1'b0;
      engineCycle();
      rstn_drv = 1'b1;
      q0.delete();
      acc0 = 0;
      acc1 = 0;
      clearLogs();
      addMsg(0, 2, 16'hD000, 1'b0);
      engineCycle();
      cmp("rst_grant", grant, 2'b00);
      cmp("rst_m_tvalid", m_tvalid, 1'b0);
      cmp("rst_m_tdata", m_tdata, 16'h0);
      cmp("rst_s0_tready", s0_tready, 1'b0);
      cmp("rst_abort", abort, 1'b0);
      cmp("rst_msg_count", msg_count, 0);
      repeat (12) engineCycle();
      cmp("rst_new_msg_count", msg_count, 1);
      cmp("rst_new_words", out_log.size(), 2);
      if (out_log.size() == 2) begin
         cmp("rst_new_w0", out_log[0], 16'hD000);
         cmp("rst_new_w1", out_log[1], 16'hD001);
      end

      // randomized traffic against the reference model
      doReset();
      rnd_mode = 1;
      repeat (3000) engineCycle();
      rnd_mode = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
